// File: rtl/axil_crossbar_rd.sv
// AXI4-Lite read-channel shared-bus crossbar: round-robin arbitration, address decode,
// one transaction at a time, with decode-error, response timeout and orphan draining.
module axil_crossbar_rd #(
    parameter int S_COUNT = 4,
    parameter int M_COUNT = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [M_COUNT*ADDR_WIDTH-1:0] M_BASE_ADDR =
        {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
    parameter logic [M_COUNT*32-1:0] M_ADDR_WIDTH = {M_COUNT{32'd24}},
    parameter int TIMEOUT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [S_COUNT*ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [S_COUNT*3-1:0]            s_axil_arprot,
    input  logic [S_COUNT-1:0]              s_axil_arvalid,
    output logic [S_COUNT-1:0]              s_axil_arready,
    output logic [S_COUNT*DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [S_COUNT*2-1:0]            s_axil_rresp,
    output logic [S_COUNT-1:0]              s_axil_rvalid,
    input  logic [S_COUNT-1:0]              s_axil_rready,
    output logic [M_COUNT*ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [M_COUNT*3-1:0]            m_axil_arprot,
    output logic [M_COUNT-1:0]              m_axil_arvalid,
    input  logic [M_COUNT-1:0]              m_axil_arready,
    input  logic [M_COUNT*DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [M_COUNT*2-1:0]            m_axil_rresp,
    input  logic [M_COUNT-1:0]              m_axil_rvalid,
    output logic [M_COUNT-1:0]              m_axil_rready
);
    localparam int SW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int MW = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, ACCEPT, ADDR, READ, RESP} state_t;
    state_t state, state_next;

    logic [SW-1:0]         grant, rr_ptr, req_idx, scan_idx;
    logic                  req_found;
    logic [MW-1:0]         m_sel, dec_idx;
    logic                  dec_hit;
    logic [M_COUNT-1:0]    dec_match;
    logic [ADDR_WIDTH-1:0] grant_addr, addr_reg;
    logic [2:0]            prot_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic [M_COUNT-1:0]    orphan, orphan_next;
    logic [TW-1:0]         tcnt;
    logic                  sel_rvalid, tmo_hit;

    assign grant_addr = s_axil_araddr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_rvalid = m_axil_rvalid[m_sel];
    assign tmo_hit    = (TIMEOUT > 0) && (tcnt == TW'(TIMEOUT));

    // Scan downward so the requester closest to the pointer is the last one written.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        scan_idx  = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            scan_idx = SW'((int'(rr_ptr) + i) % S_COUNT);
            if (s_axil_arvalid[scan_idx]) begin
                req_found = 1'b1;
                req_idx   = scan_idx;
            end
        end
    end

    for (genvar m = 0; m < M_COUNT; m++) begin : g_dec
        localparam logic [31:0] SH = M_ADDR_WIDTH[m*32 +: 32];
        localparam logic [ADDR_WIDTH-1:0] BASE = M_BASE_ADDR[m*ADDR_WIDTH +: ADDR_WIDTH];
        assign dec_match[m] = (grant_addr >> SH) == (BASE >> SH);
    end

    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int m = M_COUNT - 1; m >= 0; m--) begin
            if (dec_match[m]) begin
                dec_hit = 1'b1;
                dec_idx = MW'(m);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        m_axil_arvalid = '0;
        m_axil_rready  = orphan;
        case (state)
            IDLE:   if (req_found) state_next = ACCEPT;
            ACCEPT: begin
                s_axil_arready[grant] = 1'b1;
                state_next = (dec_hit && !orphan[dec_idx]) ? ADDR : RESP;
            end
            ADDR: begin
                m_axil_arvalid[m_sel] = 1'b1;
                if (m_axil_arready[m_sel]) state_next = READ;
            end
            READ: begin
                m_axil_rready[m_sel] = 1'b1;
                if (sel_rvalid || tmo_hit) state_next = RESP;
            end
            RESP: begin
                s_axil_rvalid[grant] = 1'b1;
                if (s_axil_rready[grant]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Late responses on orphaned ports are swallowed; a timeout marks the port orphaned.
    always_comb begin
        orphan_next = orphan & ~m_axil_rvalid;
        if (state == READ && !sel_rvalid && tmo_hit) orphan_next[m_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            rr_ptr    <= '0;
            m_sel     <= '0;
            addr_reg  <= '0;
            prot_reg  <= '0;
            rdata_reg <= '0;
            rresp_reg <= '0;
            orphan    <= '0;
            tcnt      <= '0;
        end else begin
            orphan <= orphan_next;
            case (state)
                IDLE: if (req_found) grant <= req_idx;
                ACCEPT: begin
                    addr_reg <= grant_addr;
                    prot_reg <= s_axil_arprot[int'(grant)*3 +: 3];
                    if (!dec_hit) begin
                        rresp_reg <= 2'b11;
                        rdata_reg <= '0;
                    end else if (orphan[dec_idx]) begin
                        rresp_reg <= 2'b10;
                        rdata_reg <= '0;
                    end else begin
                        m_sel <= dec_idx;
                    end
                end
                ADDR: if (m_axil_arready[m_sel]) tcnt <= '0;
                READ: begin
                    if (sel_rvalid) begin
                        rdata_reg <= m_axil_rdata[int'(m_sel)*DATA_WIDTH +: DATA_WIDTH];
                        rresp_reg <= m_axil_rresp[int'(m_sel)*2 +: 2];
                    end else if (tmo_hit) begin
                        rresp_reg <= 2'b10;
                        rdata_reg <= '0;
                    end else if (tcnt != {TW{1'b1}}) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: if (s_axil_rready[grant]) rr_ptr <= SW'((int'(grant) + 1) % S_COUNT);
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < S_COUNT; i++) begin : g_s_lane
        assign s_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdata_reg;
        assign s_axil_rresp[i*2 +: 2]                   = rresp_reg;
    end

    for (genvar i = 0; i < M_COUNT; i++) begin : g_m_lane
        assign m_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_reg;
        assign m_axil_arprot[i*3 +: 3]                   = prot_reg;
    end

endmodule
